// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, state encoding and control-bundle type for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned PCSRC_W = 2;
    localparam int unsigned WCNT_W  = 8;
    localparam int unsigned CNT_W   = 32;

    localparam logic [WCNT_W-1:0] MEM_TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic flush_ifid;
        logic en_idex;
        logic flush_idex;
        logic en_exmem;
        logic en_memwb;
        logic mem_err;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{pc_en: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b0,
                                      en_idex: 1'b1, flush_idex: 1'b0, en_exmem: 1'b1,
                                      en_memwb: 1'b1, mem_err: 1'b0};
    localparam hz_ctrl_t CTRL_OFF = '{default: 1'b0};
    localparam hz_ctrl_t CTRL_ERR = '{default: 1'b1};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; async active-low clear, optional synchronous load.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, redirect flushes, data-memory freeze
// with timeout abort, plus saturating stall and flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter logic [WCNT_W-1:0] MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   rs1_ID,
    input  logic [REG_W-1:0]   rs2_ID,
    input  logic [REG_W-1:0]   rd_EX,
    input  logic               mem_read_EX,
    input  logic [PCSRC_W-1:0] pc_src_EX,
    input  logic               mem_req_MEM,
    input  logic               dmem_ack,
    output logic               pc_en,
    output logic               en_IFID,
    output logic               flush_IFID,
    output logic               en_IDEX,
    output logic               flush_IDEX,
    output logic               en_EXMEM,
    output logic               en_MEMWB,
    output logic               mem_err,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
);

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WCNT_W:0]   wcnt_inc;
    hz_ctrl_t          ctrl, run_ctrl;
    logic              redirect, load_use, freeze_req;

    assign redirect   = (pc_src_EX != '0);
    assign load_use   = mem_read_EX && (rd_EX != '0) && ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
    assign freeze_req = mem_req_MEM && !dmem_ack;
    assign wcnt_inc   = (WCNT_W+1)'(wcnt_q) + (WCNT_W+1)'(1);

    // Normal pipeline steering; a redirect squashes the younger load-use victim, so no bubble.
    always_comb begin
        run_ctrl = CTRL_RUN;
        if (redirect) begin
            run_ctrl.flush_ifid = 1'b1;
            run_ctrl.flush_idex = 1'b1;
        end else if (load_use) begin
            run_ctrl.pc_en      = 1'b0;
            run_ctrl.en_ifid    = 1'b0;
            run_ctrl.flush_idex = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ctrl    = run_ctrl;
        case (state_q)
            ST_RUN: begin
                if (freeze_req) begin
                    ctrl    = CTRL_OFF;
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // A dropped request counts as completion.
                if (freeze_req) begin
                    ctrl   = CTRL_OFF;
                    wcnt_d = wcnt_inc[WCNT_W-1:0];
                    if (wcnt_inc >= (WCNT_W+1)'(MEM_TIMEOUT)) begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end
            end
            ST_ERR: begin
                ctrl    = CTRL_ERR;
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
        if (!rst) begin
            ctrl = CTRL_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign en_IFID    = ctrl.en_ifid;
    assign flush_IFID = ctrl.flush_ifid;
    assign en_IDEX    = ctrl.en_idex;
    assign flush_IDEX = ctrl.flush_idex;
    assign en_EXMEM   = ctrl.en_exmem;
    assign en_MEMWB   = ctrl.en_memwb;
    assign mem_err    = ctrl.mem_err;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .inc_i      (!ctrl.pc_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .inc_i      (ctrl.flush_ifid),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and short timeout) checked every cycle
// against a cycle-level model, plus hand-computed spot checks and a counter saturation check.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic       mem_read_EX = 1'b0;
    logic [1:0] pc_src_EX = '0;
    logic       mem_req_MEM = 1'b0, dmem_ack = 1'b0;

    logic [1:0]  o_pc_en, o_en_ifid, o_fl_ifid, o_en_idex, o_fl_idex, o_en_exmem, o_en_memwb, o_mem_err;
    logic [31:0] o_stall [2];
    logic [31:0] o_flush [2];

    logic        sc_inc = 1'b0, sc_ld = 1'b0;
    logic [31:0] sc_val = '0;
    logic [31:0] sc_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX),
        .mem_read_EX(mem_read_EX), .pc_src_EX(pc_src_EX), .mem_req_MEM(mem_req_MEM),
        .dmem_ack(dmem_ack), .pc_en(o_pc_en[0]), .en_IFID(o_en_ifid[0]),
        .flush_IFID(o_fl_ifid[0]), .en_IDEX(o_en_idex[0]), .flush_IDEX(o_fl_idex[0]),
        .en_EXMEM(o_en_exmem[0]), .en_MEMWB(o_en_memwb[0]), .mem_err(o_mem_err[0]),
        .stall_cycles(o_stall[0]), .flush_events(o_flush[0])
    );

    hazard_ctrl #(.MEM_TIMEOUT(8'd3)) dut_t (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX),
        .mem_read_EX(mem_read_EX), .pc_src_EX(pc_src_EX), .mem_req_MEM(mem_req_MEM),
        .dmem_ack(dmem_ack), .pc_en(o_pc_en[1]), .en_IFID(o_en_ifid[1]),
        .flush_IFID(o_fl_ifid[1]), .en_IDEX(o_en_idex[1]), .flush_IDEX(o_fl_idex[1]),
        .en_EXMEM(o_en_exmem[1]), .en_MEMWB(o_en_memwb[1]), .mem_err(o_mem_err[1]),
        .stall_cycles(o_stall[1]), .flush_events(o_flush[1])
    );

    sat_counter #(.WIDTH(32)) u_sat (
        .clk(clk), .rst_n(rst), .inc_i(sc_inc), .load_i(sc_ld), .load_val_i(sc_val), .cnt_o(sc_out)
    );

    // Bundle order: pc_en en_IFID flush_IFID en_IDEX flush_IDEX en_EXMEM en_MEMWB mem_err
    localparam logic [7:0] E_IDLE  = 8'hD6;
    localparam logic [7:0] E_LU    = 8'h1E;
    localparam logic [7:0] E_REDIR = 8'hFE;
    localparam logic [7:0] E_ERR   = 8'hFF;
    localparam logic [7:0] E_ZERO  = 8'h00;

    function automatic logic [7:0] ctl(input int i);
        return {o_pc_en[i], o_en_ifid[i], o_fl_ifid[i], o_en_idex[i], o_fl_idex[i],
                o_en_exmem[i], o_en_memwb[i], o_mem_err[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a freeze is any cycle with an unacknowledged live request; after tmo such
    // consecutive cycles the next cycle is the error cycle.
    int unsigned tmo [2] = '{255, 3};
    int unsigned fr  [2] = '{0, 0};
    bit          errn[2] = '{1'b0, 1'b0};
    longint      m_st[2] = '{0, 0};
    longint      m_fe[2] = '{0, 0};

    always @(negedge clk) begin
        logic [7:0] e;
        logic       lu;
        lu = mem_read_EX && (rd_EX != 5'd0) && (rd_EX == rs1_ID || rd_EX == rs2_ID);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                e = E_ZERO; fr[i] = 0; errn[i] = 1'b0; m_st[i] = 0; m_fe[i] = 0;
            end else if (errn[i]) begin
                e = E_ERR; errn[i] = 1'b0; fr[i] = 0;
            end else if (mem_req_MEM && !dmem_ack) begin
                e = E_ZERO;
                fr[i]++;
                if (fr[i] >= tmo[i]) errn[i] = 1'b1;
            end else begin
                fr[i] = 0;
                e = (pc_src_EX != 2'd0) ? E_REDIR : (lu ? E_LU : E_IDLE);
            end
            chk($sformatf("model_ctl%0d", i), 32'(ctl(i)), 32'(e));
            chk($sformatf("model_stall%0d", i), o_stall[i], 32'(m_st[i]));
            chk($sformatf("model_flush%0d", i), o_flush[i], 32'(m_fe[i]));
            if (rst) begin
                if (!e[7] && m_st[i] < 64'hFFFF_FFFF) m_st[i]++;
                if (e[5] && m_fe[i] < 64'hFFFF_FFFF) m_fe[i]++;
            end
        end
    end

    task automatic idle();
        rs1_ID = '0; rs2_ID = '0; rd_EX = '0; mem_read_EX = 1'b0;
        pc_src_EX = '0; mem_req_MEM = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       mr;
        logic [1:0] ps;
        logic       mq, ak;
    } vec_t;

    vec_t vecs [8] = '{
        '{5'd3, 5'd0, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0},
        '{5'd1, 5'd2, 5'd4, 1'b1, 2'd0, 1'b0, 1'b0},
        '{5'd9, 5'd9, 5'd9, 1'b1, 2'd3, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0},
        '{5'd6, 5'd0, 5'd6, 1'b1, 2'd1, 1'b1, 1'b0},
        '{5'd6, 5'd0, 5'd6, 1'b1, 2'd1, 1'b1, 1'b1},
        '{5'd2, 5'd2, 5'd2, 1'b1, 2'd0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 2'd2, 1'b0, 1'b0}
    };

    initial begin
        idle();
        cyc();
        cyc();
        chk("rst_ctl", 32'(ctl(0)), 32'(E_ZERO));
        chk("rst_stall", o_stall[0], 32'd0);
        rst = 1'b1;
        #1 chk("first_run", 32'(ctl(0)), 32'(E_IDLE));
        cyc();

        // Load-use on rs2, zero-register exemption, rs1 match, non-load match
        rd_EX = 5'd5; rs2_ID = 5'd5; mem_read_EX = 1'b1;
        #1 chk("lu_ctl", 32'(ctl(0)), 32'(E_LU));
        cyc();
        idle();
        #1 chk("lu_stall", o_stall[0], 32'd1);
        chk("lu_stall_t", o_stall[1], 32'd1);
        mem_read_EX = 1'b1;
        #1 chk("lu_x0", 32'(ctl(0)), 32'(E_IDLE));
        cyc();
        rd_EX = 5'd7; rs1_ID = 5'd7;
        #1 chk("lu_rs1", 32'(ctl(0)), 32'(E_LU));
        cyc();
        mem_read_EX = 1'b0;
        #1 chk("no_load", 32'(ctl(0)), 32'(E_IDLE));
        cyc();

        // Redirect wins over load-use
        do_reset();
        rd_EX = 5'd5; rs2_ID = 5'd5; mem_read_EX = 1'b1; pc_src_EX = 2'b01;
        #1 chk("redir_lu", 32'(ctl(0)), 32'(E_REDIR));
        cyc();
        idle();
        #1 chk("redir_fe", o_flush[0], 32'd1);
        chk("redir_st", o_stall[0], 32'd0);
        pc_src_EX = 2'b10;
        cyc();
        pc_src_EX = 2'b11;
        cyc();
        idle();

        // Memory wait released by ack after four frozen cycles
        do_reset();
        mem_req_MEM = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("mw_frz", 32'(ctl(0)), 32'(E_ZERO));
            cyc();
        end
        dmem_ack = 1'b1;
        #1 chk("mw_ack", 32'(ctl(0)), 32'(E_IDLE));
        cyc();
        idle();
        #1 chk("mw_stall", o_stall[0], 32'd4);
        mem_req_MEM = 1'b1; dmem_ack = 1'b1;
        #1 chk("ack_run", 32'(ctl(0)), 32'(E_IDLE));
        cyc();
        dmem_ack = 1'b0;
        cyc();
        dmem_ack = 1'b1; rd_EX = 5'd3; rs1_ID = 5'd3; mem_read_EX = 1'b1;
        #1 chk("ack_lu", 32'(ctl(0)), 32'(E_LU));
        cyc();
        idle();
        mem_req_MEM = 1'b1;
        cyc();
        mem_req_MEM = 1'b0;
        #1 chk("req_drop", 32'(ctl(0)), 32'(E_IDLE));
        cyc();

        // Timeout on the short-timeout instance
        do_reset();
        mem_req_MEM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("to_frz", 32'(ctl(1)), 32'(E_ZERO));
            cyc();
        end
        #1 chk("to_err", 32'(ctl(1)), 32'(E_ERR));
        chk("to_long", 32'(ctl(0)), 32'(E_ZERO));
        cyc();
        #1 chk("to_after", 32'(ctl(1)), 32'(E_ZERO));
        cyc();
        idle();
        #1 chk("to_idle", 32'(ctl(1)), 32'(E_IDLE));
        cyc();
        #1 chk("to_fe", o_flush[1], 32'd1);
        chk("to_st_t", o_stall[1], 32'd4);
        chk("to_st", o_stall[0], 32'd5);

        // Asynchronous reset in the second wait cycle
        do_reset();
        mem_req_MEM = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1 chk("arst_ctl", 32'(ctl(0)), 32'(E_ZERO));
        chk("arst_ctl_t", 32'(ctl(1)), 32'(E_ZERO));
        chk("arst_st", o_stall[0], 32'd0);
        cyc();
        idle();
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("arst_noerr", 32'(o_mem_err), 32'd0);
            cyc();
        end

        // Mixed directed vectors, checked by the model only
        for (int k = 0; k < 8; k++) begin
            rs1_ID = vecs[k].rs1; rs2_ID = vecs[k].rs2; rd_EX = vecs[k].rd;
            mem_read_EX = vecs[k].mr; pc_src_EX = vecs[k].ps;
            mem_req_MEM = vecs[k].mq; dmem_ack = vecs[k].ak;
            cyc();
        end
        idle();
        cyc();

        // Counter saturation from a preloaded value
        sc_ld = 1'b1; sc_val = 32'hFFFF_FFFE;
        cyc();
        sc_ld = 1'b0; sc_inc = 1'b1;
        #1 chk("sat_pre", sc_out, 32'hFFFF_FFFE);
        cyc();
        #1 chk("sat_max", sc_out, 32'hFFFF_FFFF);
        cyc();
        cyc();
        #1 chk("sat_hold", sc_out, 32'hFFFF_FFFF);
        sc_inc = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255, maximum consecutive MEM_WAIT cycles before abort.
REQ-002 Port list, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-low reset (0 = reset asserted).
  rs1_ID  in  5  ID-stage source register 1.
  rs2_ID  in  5  ID-stage source register 2.
  rd_EX  in  5  EX-stage destination register.
  mem_read_EX  in  1  EX-stage instruction is a load.
  pc_src_EX  in  2  EX redirect select; nonzero = taken branch/jump.
  mem_req_MEM  in  1  MEM stage has an outstanding data-memory access.
  dmem_ack  in  1  data memory completes the access this cycle.
  pc_en  out  1  PC register update enable.
  en_IFID, flush_IFID  out  1 each  IF/ID register controls.
  en_IDEX, flush_IDEX  out  1 each  ID/EX register controls.
  en_EXMEM, en_MEMWB  out  1 each  downstream register enables.
  mem_err  out  1  one-cycle pulse on memory timeout.
  stall_cycles  out  32  saturating count of cycles with pc_en=0.
  flush_events  out  32  saturating count of cycles with flush_IFID=1.

Function
REQ-003 FSM states: RUN, MEM_WAIT, ERR; 8-bit wait counter wcnt.
REQ-004 Control outputs are combinational from state and inputs; state, wcnt, and the counters are registered.
REQ-005 Default in RUN: all enables 1, all flushes 0, mem_err 0.
REQ-006 Load-use in RUN: mem_read_EX=1, rd_EX!=0, and rd_EX equals rs1_ID or rs2_ID.
  Response: pc_en=0, en_IFID=0, en_IDEX=1, flush_IDEX=1.
  Bubble lasts exactly one cycle; the hazard then clears naturally.
REQ-007 Redirect in RUN: pc_src_EX!=0 gives flush_IFID=1 and flush_IDEX=1, all enables 1.
REQ-008 Redirect overrides load-use when both occur in the same cycle; no stall is applied.
REQ-009 RUN with mem_req_MEM=1 and dmem_ack=0:
  - freeze the same cycle: all enables 0, flushes 0;
  - next state MEM_WAIT, wcnt<=1.
  Freeze overrides redirect and load-use; those re-evaluate after release.
REQ-010 RUN with mem_req_MEM=1 and dmem_ack=1: no freeze; state stays RUN.
REQ-011 MEM_WAIT with dmem_ack=1: enables released the same cycle (RUN rules apply to the other inputs); next state RUN, wcnt<=0.
REQ-012 MEM_WAIT with dmem_ack=0:
  - all enables 0;
  - wcnt increments;
  - when wcnt==MEM_TIMEOUT, next state ERR.
REQ-013 MEM_WAIT with mem_req_MEM dropping to 0 without ack is treated as ack (REQ-011).
REQ-014 ERR (exactly one cycle):
  - mem_err=1, flush_IFID=1, flush_IDEX=1, all enables 1;
  - next state RUN, wcnt<=0.
REQ-015 Counters:
  - stall_cycles increments each cycle pc_en=0;
  - flush_events increments each cycle flush_IFID=1;
  - both hold at 32'hFFFF_FFFF and never wrap.

Reset
REQ-016 While rst=0:
  - all enables 0, all flushes 0, mem_err 0;
  - state RUN, wcnt 0, stall_cycles 0, flush_events 0.
REQ-017 Reset asserted mid-MEM_WAIT or mid-ERR aborts immediately to RUN with no mem_err pulse.
REQ-018 Counters do not count during reset; on the first cycle after rst rises, RUN rules apply.

Structure
REQ-019 State encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the MEM_TIMEOUT default live in the shared CPU constants package/header.
REQ-020 One sub-module, sat_counter (32-bit, inc, synchronous hold at max, asynchronous active-low clear), is instantiated twice.

Verification
REQ-021 Load-use: rd_EX=5, mem_read_EX=1, rs2_ID=5 for 1 cycle -> pc_en=0, en_IFID=0, flush_IDEX=1; stall_cycles=1.
REQ-022 Redirect plus load-use: pc_src_EX=2'b01 with REQ-021 inputs -> flush_IFID=1, flush_IDEX=1, pc_en=1; flush_events=1, stall_cycles=0.
REQ-023 Memory wait: mem_req_MEM=1, ack after 4 cycles -> enables 0 for 4 cycles, all 1 in the ack cycle; stall_cycles=4.
REQ-024 Timeout: MEM_TIMEOUT=3, no ack -> 3 freeze cycles, then one ERR cycle with mem_err=1 and flush_IFID=1, then RUN.
REQ-025 Reset mid-wait: rst=0 in the second MEM_WAIT cycle -> all outputs 0 asynchronously, counters 0, no mem_err after release.
REQ-026 Saturation: preload stall_cycles to 32'hFFFF_FFFE, stall 3 cycles -> reads 32'hFFFF_FFFF.
